// File: rtl/async_fifo_wr_arb_if.sv
// Handshake bundle between the requesters, the write arbiter and the FIFO write side.
// The arbiter connects through the slave modport; producers and the FIFO side use master.
interface async_fifo_wr_arb_if #(
  parameter int unsigned BITS = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) ();
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][BITS-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      fifo_wr_full;
  logic                      fifo_wr_en;
  logic [BITS-1:0]           fifo_wr_data;
  logic                      grant_valid;
  logic [IDW-1:0]            grant_id;

  modport slave (
    input  req_valid, req_data, fifo_wr_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_wr_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );
endinterface

// File: rtl/async_fifo_wr_arb.sv
// Round-robin write-port arbiter for async_fifo: NREQ valid/ready requesters share one
// write port, each grant carrying a burst of up to MAX_BURST entries.
module async_fifo_wr_arb #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                wr_clk,
  input  logic                wr_rst_n,
  async_fifo_wr_arb_if.slave  bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BCW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;
  logic           found;
  logic           in_grant;
  logic           cur_valid;
  logic           xfer;

  // Scan starts just past the last grantee so it ends up with lowest priority.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_id_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign in_grant  = (state_q == GRANT);
  assign cur_valid = bus.req_valid[grant_id_q];
  assign xfer      = in_grant && cur_valid && !bus.fifo_wr_full;

  // Full gates ready and write enable combinationally so the FIFO never drops a write.
  always_comb begin
    bus.req_ready = '0;
    if (in_grant) bus.req_ready[grant_id_q] = !bus.fifo_wr_full;
  end

  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = in_grant ? bus.req_data[grant_id_q] : '0;
  assign bus.grant_valid  = in_grant;
  assign bus.grant_id     = in_grant ? grant_id_q : '0;

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      if (|bus.req_valid) begin
        state_d     = GRANT;
        grant_id_d  = pick;
        last_id_d   = pick;
        burst_cnt_d = '0;
      end
    end else begin
      if (!cur_valid) begin
        state_d = IDLE;
      end else if (xfer) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        if (burst_cnt_q == BCW'(MAX_BURST - 1)) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_id_q   <= IDW'(NREQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Scoreboard bench for async_fifo_wr_arb: directed requester streams, expected writes
// (requester id, data, cycles since previous write) queued up front, checked by a monitor.
module tb_async_fifo_wr_arb;
  localparam int unsigned BITS = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  async_fifo_wr_arb_if #(.BITS(BITS), .NREQ(NREQ)) bus ();

  async_fifo_wr_arb #(.BITS(BITS), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .wr_clk   (clk),
    .wr_rst_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int unsigned gap;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] src_mem [NREQ][16];
  int unsigned src_len [NREQ];
  int unsigned src_gen = 0;
  int unsigned full_len = 0;
  int unsigned full_gen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] d, input int unsigned gap);
    exp_t e;
    e.id = id; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic load(input int unsigned r, input logic [31:0] base, input int unsigned n);
    for (int unsigned w = 0; w < n; w++) src_mem[r][w] = base + w;
    src_len[r] = n;
  endtask

  // Requester and full driver: inputs change 1 time unit after the rising edge.
  initial begin
    int unsigned      ptr [NREQ];
    int unsigned      seen_src = 0;
    int unsigned      seen_full = 0;
    int unsigned      full_left = 0;
    logic [NREQ-1:0]  xs;
    for (int unsigned i = 0; i < NREQ; i++) ptr[i] = 0;
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.fifo_wr_full = 1'b0;
    forever begin
      @(negedge clk);
      xs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      if (src_gen != seen_src) begin
        seen_src = src_gen;
        for (int unsigned i = 0; i < NREQ; i++) ptr[i] = 0;
        xs = '0;
      end
      if (full_gen != seen_full) begin
        seen_full = full_gen;
        full_left = full_len;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (xs[i]) ptr[i]++;
        if (ptr[i] < src_len[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i]  = src_mem[i][ptr[i]];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i]  = '0;
        end
      end
      bus.fifo_wr_full = (full_left != 0);
      if (full_left != 0) full_left--;
    end
  end

  // Monitor: pops the scoreboard on every FIFO write and polices back-pressure.
  initial begin
    int unsigned cyc = 0;
    int unsigned last_wr = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_wr_full) begin
        chk("wr_en_while_full", 64'(bus.fifo_wr_en), 64'd0);
        chk("ready_while_full", 64'(bus.req_ready), 64'd0);
        chk("grant_held_full", 64'(bus.grant_valid), 64'd1);
      end
      if (bus.fifo_wr_en) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got data %0h id %0d want no write",
                   bus.fifo_wr_data, bus.grant_id);
        end else begin
          e = sb.pop_front();
          chk("wr_data", 64'(bus.fifo_wr_data), 64'(e.data));
          chk("wr_id", 64'(bus.grant_id), 64'(e.id));
          if (e.gap != 0) chk("wr_gap", 64'(cyc - last_wr), 64'(e.gap));
        end
        last_wr = cyc;
      end
    end
  end

  task automatic clear_src();
    for (int unsigned i = 0; i < NREQ; i++) src_len[i] = 0;
    src_gen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_src();
    full_len = 0;
    full_gen++;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    chk("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    int unsigned c = 0;
    while (sb.size() != 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_data(input logic [31:0] d);
    int unsigned c = 0;
    while (!(bus.fifo_wr_en && bus.fifo_wr_data == d) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("wait_for_write", 64'(bus.fifo_wr_en && bus.fifo_wr_data == d), 64'd1);
  endtask

  initial begin
    for (int unsigned i = 0; i < NREQ; i++) src_len[i] = 0;

    // Single requester: 4-word burst, one IDLE cycle, then the last two words.
    do_reset();
    push(2'd0, 32'h10, 0); push(2'd0, 32'h11, 1); push(2'd0, 32'h12, 1);
    push(2'd0, 32'h13, 1); push(2'd0, 32'h14, 2); push(2'd0, 32'h15, 1);
    load(0, 32'h10, 6);
    src_gen++;
    @(posedge clk);
    @(negedge clk);
    chk("lat_idle_grant", 64'(bus.grant_valid), 64'd0);
    @(negedge clk);
    chk("lat_grant_valid", 64'(bus.grant_valid), 64'd1);
    chk("lat_grant_id", 64'(bus.grant_id), 64'd0);
    chk("lat_req_ready", 64'(bus.req_ready), 64'h1);
    drain();

    // Round-robin: four continuous requesters, 8 words each, grants 0,1,2,3,0,1,2,3.
    do_reset();
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned i = 0; i < NREQ; i++)
        for (int unsigned w = 0; w < MAXB; w++)
          push(2'(i), 32'(i * 256 + r * MAXB + w),
               (r == 0 && i == 0 && w == 0) ? 0 : ((w == 0) ? 2 : 1));
    for (int unsigned i = 0; i < NREQ; i++) load(i, 32'(i * 256), 8);
    src_gen++;
    drain();

    // Early release: requester 1 stops after 2 words, requester 3 follows after one IDLE cycle.
    do_reset();
    push(2'd1, 32'h30, 0); push(2'd1, 32'h31, 1);
    push(2'd3, 32'h50, 3); push(2'd3, 32'h51, 1);
    load(1, 32'h30, 2);
    load(3, 32'h50, 2);
    src_gen++;
    drain();

    // Full stall: 5 full cycles after requester 2's second word.
    do_reset();
    push(2'd2, 32'h20, 0); push(2'd2, 32'h21, 1);
    push(2'd2, 32'h22, 6); push(2'd2, 32'h23, 1);
    load(2, 32'h20, 4);
    src_gen++;
    wait_data(32'h21);
    full_len = 5;
    full_gen++;
    drain();

    // Async reset during requester 1's second transfer, then fresh priority from 0.
    do_reset();
    push(2'd1, 32'h40, 0); push(2'd1, 32'h41, 1);
    load(1, 32'h40, 4);
    src_gen++;
    wait_data(32'h41);
    #2;
    rst_n = 1'b0;
    clear_src();
    #1;
    chk("arst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("arst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    chk("arst_grant_valid", 64'(bus.grant_valid), 64'd0);
    chk("arst_grant_id", 64'(bus.grant_id), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(2'd0, 32'h60, 0); push(2'd1, 32'h61, 3);
    push(2'd2, 32'h62, 3); push(2'd3, 32'h63, 3);
    for (int unsigned i = 0; i < NREQ; i++) load(i, 32'(32'h60 + i), 1);
    src_gen++;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/async_fifo_wr_arb.md
# async_fifo_wr_arb

Write-domain arbiter that shares the single write port of `async_fifo` among `NREQ` requesters. Each requester has a valid/ready handshake. The arbiter grants one requester at a time in round-robin order and lets it write a burst of up to `MAX_BURST` entries. It stalls on `wr_full` and drives the FIFO's `wr_en`/`wr_data` directly. It sits in the `wr_clk` domain, between producer blocks and the FIFO write side.

## Interface
- `BITS`, 32, entry width; must match the FIFO `BITS`.
- `NREQ`, 4, number of requesters; ≥2.
- `MAX_BURST`, 4, maximum transfers per grant; ≥1.

- `wr_clk`  in  1  write-domain clock; the only clock.
- `wr_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester data valid.
- `req_data`  in  NREQ×BITS  per-requester data; `req_data[i]` pairs with `req_valid[i]`.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set.
- `fifo_wr_full`  in  1  from FIFO `wr_full`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_wr_data`  out  BITS  to FIFO `wr_data`.
- `grant_valid`  out  1  a grant is active (state GRANT).
- `grant_id`  out  max(1,$clog2(NREQ))  index of the granted requester; valid when `grant_valid`=1.

## Operation
- **States**
  - IDLE: no grant.
  - GRANT: `grant_id` owns the port.
- **Arbitration (IDLE)**
  - If any `req_valid` is set, pick the first set bit scanning from `last_id+1` upward, modulo NREQ.
  - Register that index into `grant_id` and `last_id`, clear `burst_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- **Transfer handshake (GRANT)**
  - `req_ready[grant_id] = !fifo_wr_full`, combinational; all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[grant_id] && req_ready[grant_id]`.
  - `fifo_wr_en` equals the transfer signal.
  - `fifo_wr_data = req_data[grant_id]` while in GRANT; 0 in IDLE.
  - The arbiter never asserts `fifo_wr_en` while `fifo_wr_full`=1, so no write is ever dropped by the FIFO.
- **Burst counter**
  - `burst_cnt` is $clog2(MAX_BURST)+1 bits wide and increments once per transfer.
- **Release (GRANT→IDLE, registered)**
  - (a) A transfer occurs with `burst_cnt == MAX_BURST-1`, or
  - (b) `req_valid[grant_id]` = 0 in a GRANT cycle; the requester abandons the grant.
  - While `fifo_wr_full`=1 with valid held, the grant is held indefinitely; a full stall never releases.
- **Fairness**
  - `last_id` records the last granted index. A requester that just held the grant has lowest priority at the next arbitration.
  - Any continuously valid requester is granted within NREQ-1 other grants.
- **Requester rule**
  - Once `req_valid[i]` is asserted with `req_ready[i]`=0, `req_data[i]` must stay stable.
  - Deasserting `req_valid[i]` before acceptance is legal for requester `i`. If `i` is currently granted, it releases the grant per (b).
- **Reset**
  - `wr_rst_n`=0 forces IDLE immediately, including mid-burst.
  - `last_id` resets to NREQ-1, so requester 0 has first priority.
  - `burst_cnt` and `grant_id` reset to 0.
  - With state in IDLE, all outputs are 0: `req_ready`, `fifo_wr_en`, `fifo_wr_data`, `grant_valid`, `grant_id`.
  - A burst interrupted by reset is not resumed.

## Timing
- **Arbitration latency:** `req_valid` rising in cycle n (state IDLE) → `grant_valid`=1 and `req_ready` possible in cycle n+1.
- **Throughput within a grant:** 1 entry/cycle while not full.
- **Grant gap:** one IDLE cycle between consecutive grants. A full-rate burst of MAX_BURST entries therefore occupies MAX_BURST+1 cycles, including arbitration.
- **Back-pressure path:** `req_ready` and `fifo_wr_en` respond combinationally to `fifo_wr_full` in the same cycle. No registered path exists from full to `wr_en`.
- **Simultaneous events:**
  - Release by (a) together with new requests: the next arbitration happens in the following IDLE cycle.
  - Grantee drops valid in the same cycle `fifo_wr_full` rises: release per (b); no transfer.

## Test plan
- **Single requester:** reset; `req_valid[0]`=1 with data 0x10..0x15, FIFO never full.
  - `grant_id`=0 one cycle after valid.
  - Writes 0x10–0x13 on 4 consecutive cycles, then 1 IDLE cycle, then 0x14–0x15.
  - FIFO content in order.
- **Round-robin:** all 4 requesters valid continuously, each sending 8 words.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each grant carries exactly 4 writes.
  - No requester is skipped.
- **Full stall:** requester 2 granted; force `fifo_wr_full`=1 for 5 cycles mid-burst.
  - `fifo_wr_en` and `req_ready[2]` are 0 for exactly those cycles.
  - The grant is held.
  - The burst resumes with the next word, no loss or duplicate.
- **Early release:** requester 1 valid for 2 words only, requester 3 waiting.
  - After 2 transfers, `req_valid[1]` drops.
  - Next cycle IDLE; then `grant_id`=3.
- **Async reset mid-burst:** assert `wr_rst_n`=0 during requester 1's 2nd transfer.
  - Outputs go to 0 without waiting for a clock edge.
  - After release, requester 0 is granted first when all are valid.
- **End-to-end:** run with `async_fifo` at unrelated `rd_clk`, random valid/full patterns, 10k words.
  - Scoreboard: per-requester order preserved.
  - No write occurs while `wr_full`=1.
